// File: rtl/pvr_vram_pkg.sv
// Shared VRAM-side definitions for the PVR codebook/texel fetch path.
//   state_e   : fetch controller FSM states
//   CB_WORDS  : words in one VQ codebook
//   CB_OFF_W  : width of a codebook word index
//   VRAM_DW   : VRAM word width in bits
package pvr_vram_pkg;

  localparam int CB_WORDS = 256;
  localparam int CB_OFF_W = $clog2(CB_WORDS);
  localparam int VRAM_DW  = 64;

  typedef enum logic [2:0] {
    IDLE,
    CB_REQ,
    CB_DATA,
    TX_REQ,
    TX_DATA
  } state_e;

endpackage

// File: rtl/codebook_fetch_ctrl.sv
// Codebook / texel fetch controller.
// Shares one VRAM read port between the VQ codebook cache fill path and a
// single-word texel requester. Codebook fills run as a series of BURST-word
// reads and have priority over texel fetches, but never preempt one.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   cb_fill_req, cb_offset    cache: fill in progress, next word index expected
//   cb_base                   codebook word base address (latched at fill start)
//   cb_valid, cb_data         one codebook word delivered to the cache
//   tex_req, tex_addr         texel read request (held until tex_ack)
//   tex_ack                   one-cycle request-accepted pulse
//   tex_valid, tex_data       one-cycle texel data return
//   vram_rd/addr/len          VRAM read request (held while vram_wait)
//   vram_wait                 VRAM port stall
//   vram_valid, vram_din      VRAM return data
//   err_spurious              sticky: return data seen with no read outstanding
module codebook_fetch_ctrl
  import pvr_vram_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int BURST  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cb_fill_req,
  input  logic [CB_OFF_W-1:0] cb_offset,
  input  logic [ADDR_W-1:0]   cb_base,
  output logic                cb_valid,
  output logic [VRAM_DW-1:0]  cb_data,
  input  logic                tex_req,
  input  logic [ADDR_W-1:0]   tex_addr,
  output logic                tex_ack,
  output logic                tex_valid,
  output logic [VRAM_DW-1:0]  tex_data,
  output logic                vram_rd,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic [7:0]          vram_len,
  input  logic                vram_wait,
  input  logic                vram_valid,
  input  logic [VRAM_DW-1:0]  vram_din,
  output logic                err_spurious
);

  // Word counter runs 0..BURST while draining, then one extra settle step
  // so the cache's registered view of the last word can retire cb_fill_req.
  localparam logic [8:0]          BURST_CNT  = 9'(BURST);
  localparam logic [8:0]          SETTLE_CNT = 9'(BURST + 1);
  localparam logic [CB_OFF_W-1:0] OFF_MASK   = ~CB_OFF_W'(BURST - 1);
  localparam logic [7:0]          CB_LEN     = 8'(BURST - 1);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   cb_base_q;
  logic [ADDR_W-1:0]   tex_addr_q;
  logic [8:0]          word_cnt;
  logic                abort_q;   // fill dropped mid-burst: drain silently
  logic                outstanding;

  assign outstanding = ((state == CB_DATA) && (word_cnt < BURST_CNT)) ||
                       (state == TX_DATA);

  // NOTE: every output of a combinational block gets a default before the
  // case statement; any path that skipped an assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    vram_rd   = 1'b0;
    vram_addr = '0;
    vram_len  = '0;
    unique case (state)
      IDLE: begin
        if (cb_fill_req)  state_nxt = CB_REQ;
        else if (tex_req) state_nxt = TX_REQ;
      end
      CB_REQ: begin
        vram_rd   = 1'b1;
        // Burst-aligned word index of the next word the cache expects.
        vram_addr = cb_base_q + ADDR_W'(cb_offset & OFF_MASK);
        vram_len  = CB_LEN;
        if (!vram_wait) state_nxt = CB_DATA;
      end
      CB_DATA: begin
        if (word_cnt == SETTLE_CNT)
          state_nxt = (cb_fill_req && !abort_q) ? CB_REQ : IDLE;
      end
      TX_REQ: begin
        vram_rd   = 1'b1;
        vram_addr = tex_addr_q;
        if (!vram_wait) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (vram_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cb_base_q    <= '0;
      tex_addr_q   <= '0;
      word_cnt     <= '0;
      abort_q      <= 1'b0;
      cb_valid     <= 1'b0;
      // NOTE: the data registers are reset too, so every output is 0 out of
      // reset rather than X until the first transfer.
      cb_data      <= '0;
      tex_ack      <= 1'b0;
      tex_valid    <= 1'b0;
      tex_data     <= '0;
      err_spurious <= 1'b0;
    end else begin
      state     <= state_nxt;
      cb_valid  <= 1'b0;
      tex_ack   <= 1'b0;
      tex_valid <= 1'b0;

      if (vram_valid && !outstanding) err_spurious <= 1'b1;

      unique case (state)
        IDLE: begin
          if (cb_fill_req) begin
            // Offset 0 means a fresh fill; otherwise resume with the old base.
            if (cb_offset == '0) cb_base_q <= cb_base;
          end else if (tex_req) begin
            tex_ack    <= 1'b1;
            tex_addr_q <= tex_addr;
          end
        end
        CB_REQ: begin
          if (!vram_wait) begin
            word_cnt <= '0;
            abort_q  <= 1'b0;
          end
        end
        CB_DATA: begin
          if (!cb_fill_req) abort_q <= 1'b1;
          if (word_cnt < BURST_CNT) begin
            if (vram_valid) begin
              word_cnt <= word_cnt + 9'd1;
              if (cb_fill_req && !abort_q) begin
                cb_valid <= 1'b1;
                cb_data  <= vram_din;
              end
            end
          end else if (word_cnt == BURST_CNT) begin
            word_cnt <= SETTLE_CNT;
          end
        end
        TX_DATA: begin
          if (vram_valid) begin
            tex_valid <= 1'b1;
            tex_data  <= vram_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codebook_fetch_ctrl.sv
// Self-checking bench for codebook_fetch_ctrl: a behavioural codebook cache,
// a VRAM model with configurable latency/spacing/stalls, and a scoreboard of
// expected VRAM requests, codebook words and texel words.
module tb_codebook_fetch_ctrl;
  import pvr_vram_pkg::*;

  localparam int ADDR_W = 20;
  localparam int BURST  = 8;
  localparam logic [ADDR_W-1:0] TEX_MAGIC = 20'h5C0FE;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                cb_fill_req, cb_valid, tex_req, tex_ack, tex_valid;
  logic [7:0]          cb_offset, vram_len;
  logic [ADDR_W-1:0]   cb_base, tex_addr, vram_addr;
  logic [63:0]         cb_data, tex_data, vram_din;
  logic                vram_rd, vram_wait, vram_valid, err_spurious;

  codebook_fetch_ctrl #(.ADDR_W(ADDR_W), .BURST(BURST)) dut (
    .clock(clock), .reset_n(reset_n),
    .cb_fill_req(cb_fill_req), .cb_offset(cb_offset), .cb_base(cb_base),
    .cb_valid(cb_valid), .cb_data(cb_data),
    .tex_req(tex_req), .tex_addr(tex_addr), .tex_ack(tex_ack),
    .tex_valid(tex_valid), .tex_data(tex_data),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_len(vram_len),
    .vram_wait(vram_wait), .vram_valid(vram_valid), .vram_din(vram_din),
    .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [63:0] d; int due; } resp_t;

  req_t        exp_req[$];
  logic [63:0] exp_cb[$];
  logic [63:0] exp_tex[$];
  resp_t       resp_q[$];

  int checks = 0, errors = 0;
  // Environment knobs (written by the main sequence only).
  int lat = 3, gap = 1, stall_idx = -1, stall_cycles = 0, abort_after = 0;
  bit rand_wait = 1'b0, exp_err = 1'b0;
  int fill_tok = 0, spur_tok = 0;
  logic [ADDR_W-1:0] fill_base = '0;
  // Counters owned by the monitor / VRAM model.
  int cb_rx_cnt = 0, tex_ack_cnt = 0, stall_seen = 0, n_acc = 0, cyc = 0;

  // VRAM contents: a distinct word per address, plus one marked texel word.
  function automatic logic [63:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == TEX_MAGIC) return 64'hDEADBEEF_00C0FFEE;
    return {12'h5A0, a, 12'h3C1, ~a};
  endfunction

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin : monitor
    logic [63:0] e;
    req_t        r;
    if (reset_n) begin
      if (cb_valid) begin
        cb_rx_cnt++;
        if (exp_cb.size() == 0) check("cb_unexpected", 1'b0, cb_data, 64'h0);
        else begin
          e = exp_cb.pop_front();
          check("cb_data", cb_data == e, cb_data, e);
        end
      end
      if (tex_ack) begin
        tex_ack_cnt++;
        check("tex_ack_no_fill", cb_fill_req == 1'b0, 64'(cb_fill_req), 64'h0);
      end
      if (tex_valid) begin
        if (exp_tex.size() == 0) check("tex_unexpected", 1'b0, tex_data, 64'h0);
        else begin
          e = exp_tex.pop_front();
          check("tex_data", tex_data == e, tex_data, e);
        end
      end
      if (vram_rd) begin
        if (exp_req.size() == 0) check("rd_unexpected", 1'b0, 64'(vram_addr), 64'h0);
        else begin
          r = exp_req[0];
          check("rd_addr", vram_addr == r.addr, 64'(vram_addr), 64'(r.addr));
          check("rd_len", vram_len == r.len, 64'(vram_len), 64'(r.len));
          if (!vram_wait) exp_req.delete(0);
        end
        if (vram_wait) begin
          stall_seen++;
          check("stall_no_cb", cb_valid == 1'b0, 64'(cb_valid), 64'h0);
        end
      end
      check("err_spurious", err_spurious == exp_err, 64'(err_spurious), 64'(exp_err));
    end
  end

  // ---------------- codebook cache model ----------------
  initial begin : cache_model
    int seen, fill_seen, fill_words;
    cb_fill_req = 1'b0; cb_offset = '0; cb_base = '0;
    seen = 0; fill_seen = 0; fill_words = 0;
    forever begin
      @(posedge clock); #2;
      if (!reset_n) begin
        cb_fill_req = 1'b0; cb_offset = '0;
        seen = cb_rx_cnt; fill_seen = fill_tok;
      end else begin
        if (cb_rx_cnt != seen) begin
          seen = cb_rx_cnt;
          fill_words++;
          cb_offset = cb_offset + 8'd1;
          if (cb_offset == 8'd0) cb_fill_req = 1'b0;
          else if (abort_after != 0 && fill_words == abort_after) begin
            cb_fill_req = 1'b0;
            cb_offset   = '0;
          end
        end
        if (fill_tok != fill_seen) begin
          fill_seen   = fill_tok;
          cb_base     = fill_base;
          cb_offset   = '0;
          cb_fill_req = 1'b1;
          fill_words  = 0;
        end
      end
    end
  end

  // ---------------- VRAM model ----------------
  initial begin : vram_model
    int spur_seen, stall_used, last_due, due;
    vram_wait = 1'b0; vram_valid = 1'b0; vram_din = '0;
    spur_seen = 0; stall_used = 0; last_due = 0;
    forever begin
      @(posedge clock); #3;
      cyc++;
      if (!reset_n) begin
        resp_q.delete();
        vram_valid = 1'b0; vram_wait = 1'b0; last_due = 0;
        spur_seen = spur_tok;
      end else begin
        if (spur_tok != spur_seen) begin
          spur_seen = spur_tok;
          vram_valid = 1'b1; vram_din = 64'hBAD0_BAD0_BAD0_BAD0;
        end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
          vram_valid = 1'b1; vram_din = resp_q[0].d;
          resp_q.delete(0);
        end else begin
          vram_valid = 1'b0; vram_din = {$urandom, $urandom};
        end
        if (vram_rd) begin
          if (n_acc == stall_idx && stall_used < stall_cycles) begin
            vram_wait = 1'b1; stall_used++;
          end else vram_wait = rand_wait && ($urandom_range(0, 3) == 0);
        end else vram_wait = 1'b0;
      end
      @(negedge clock);
      if (reset_n && vram_rd && !vram_wait) begin
        for (int i = 0; i <= int'(vram_len); i++) begin
          due = (last_due + gap > cyc + lat) ? last_due + gap : cyc + lat;
          resp_q.push_back('{d: mem_word(vram_addr + ADDR_W'(i)), due: due});
          last_due = due;
        end
        n_acc++;
        stall_used = 0;
      end
    end
  end

  // ---------------- reference model: expected traffic ----------------
  task automatic step();
    @(posedge clock); #1;
  endtask

  // A fill of nwords from offset 0: ceil(nwords/BURST) aligned bursts and
  // the codebook words in address order, all modulo 2^ADDR_W.
  task automatic start_fill(input logic [ADDR_W-1:0] base, input int nwords);
    for (int k = 0; k < (nwords + BURST - 1) / BURST; k++)
      exp_req.push_back('{addr: base + ADDR_W'(k * BURST), len: 8'(BURST - 1)});
    for (int i = 0; i < nwords; i++) exp_cb.push_back(mem_word(base + ADDR_W'(i)));
    fill_base = base;
    fill_tok++;
  endtask

  task automatic issue_tex(input logic [ADDR_W-1:0] a);
    exp_req.push_back('{addr: a, len: 8'd0});
    exp_tex.push_back(mem_word(a));
    tex_addr = a;
    tex_req  = 1'b1;
  endtask

  task automatic wait_ack(input int budget);
    int start, n;
    start = tex_ack_cnt; n = 0;
    while (tex_ack_cnt == start && n < budget) begin step(); n++; end
    check("tex_ack_seen", tex_ack_cnt != start, 64'(n), 64'(budget));
    tex_req = 1'b0;
    tex_addr = ADDR_W'($urandom);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_cb.size() == 0 && exp_req.size() == 0 && exp_tex.size() == 0 &&
             resp_q.size() == 0 && !cb_fill_req && !tex_req) && n < budget) begin
      @(negedge clock); n++;
    end
    if (n >= budget) check({name, "_timeout"}, 1'b0, 64'(n), 64'(budget));
    repeat (6) @(negedge clock);
    check({name, "_idle_rd"}, vram_rd == 1'b0, 64'(vram_rd), 64'h0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int c0, n0, s0, n;
    logic [ADDR_W-1:0] b;
    tex_req = 1'b0; tex_addr = '0;

    // Reset state.
    #1;
    check("rst_cb_valid", cb_valid == 1'b0, 64'(cb_valid), 64'h0);
    check("rst_vram_rd", vram_rd == 1'b0, 64'(vram_rd), 64'h0);
    check("rst_tex", {tex_ack, tex_valid} == 2'b00, 64'({tex_ack, tex_valid}), 64'h0);
    check("rst_err", err_spurious == 1'b0, 64'(err_spurious), 64'h0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();

    // Cold fill at 0x01000, 3-cycle latency, no stalls.
    c0 = cb_rx_cnt; lat = 3; gap = 1; rand_wait = 1'b0;
    start_fill(20'h01000, CB_WORDS);
    wait_quiet("cold_fill", 5000);
    check("cold_fill_words", cb_rx_cnt - c0 == CB_WORDS, 64'(cb_rx_cnt - c0), 64'(CB_WORDS));

    // Fill and texel request raised in the same cycle: fill wins.
    step();
    n0 = tex_ack_cnt;
    start_fill(20'h3A5F0, CB_WORDS);
    issue_tex(TEX_MAGIC);
    wait_ack(5000);
    wait_quiet("same_cycle", 5000);
    check("same_cycle_acks", tex_ack_cnt - n0 == 1, 64'(tex_ack_cnt - n0), 64'h1);

    // Fill raised while a texel read is in flight: texel completes first.
    lat = 6;
    step();
    n0 = n_acc;
    issue_tex(20'h7_1234);
    wait_ack(200);
    n = 0;
    while (n_acc == n0 && n < 200) begin step(); n++; end
    start_fill(20'h0_8000, CB_WORDS);
    wait_quiet("tex_then_fill", 5000);

    // Five-cycle stall on the second burst.
    lat = 2;
    step();
    s0 = stall_seen;
    stall_idx = n_acc + 1; stall_cycles = 5;
    start_fill(20'h4_2200, CB_WORDS);
    wait_quiet("stall", 5000);
    check("stall_cycles", stall_seen - s0 == 5, 64'(stall_seen - s0), 64'h5);
    stall_idx = -1;

    // Cache clears after word 3: remaining words drained silently.
    gap = 3; abort_after = 4;
    step();
    c0 = cb_rx_cnt;
    start_fill(20'h1_1110, 4);
    wait_quiet("abort", 2000);
    check("abort_words", cb_rx_cnt - c0 == 4, 64'(cb_rx_cnt - c0), 64'h4);
    abort_after = 0; gap = 1;
    step();
    issue_tex(20'h2_0202);
    wait_ack(200);
    wait_quiet("after_abort_tex", 500);

    // Randomized mix, first round straddling the top of the address space.
    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(1, 4); gap = $urandom_range(1, 2); rand_wait = 1'b1;
      b = (r == 0) ? 20'hFFFC4 : ADDR_W'($urandom);
      step();
      case ($urandom_range(0, 2))
        0: start_fill(b, CB_WORDS);
        1: begin issue_tex(ADDR_W'($urandom)); wait_ack(200); end
        default: begin
          start_fill(b, CB_WORDS);
          issue_tex(ADDR_W'($urandom));
          wait_ack(5000);
        end
      endcase
      wait_quiet("random", 5000);
    end
    rand_wait = 1'b0; lat = 3;

    // Spurious return in IDLE sets the sticky error.
    step();
    spur_tok++;
    step();
    exp_err = 1'b1;
    repeat (5) step();
    check("err_sticky", err_spurious == 1'b1, 64'(err_spurious), 64'h1);

    // Reset in the middle of a codebook burst.
    c0 = cb_rx_cnt;
    start_fill(20'h6_0000, CB_WORDS);
    n = 0;
    while (cb_rx_cnt - c0 < 10 && n < 500) begin step(); n++; end
    check("mid_fill_reached", cb_rx_cnt - c0 >= 10, 64'(cb_rx_cnt - c0), 64'd10);
    reset_n = 1'b0;
    #1;
    check("mrst_cb", {cb_valid, cb_data} == 65'h0, cb_data, 64'h0);
    check("mrst_tex", {tex_ack, tex_valid, tex_data} == 66'h0, tex_data, 64'h0);
    check("mrst_rd", {vram_rd, vram_addr, vram_len} == '0, 64'(vram_addr), 64'h0);
    check("mrst_err", err_spurious == 1'b0, 64'(err_spurious), 64'h0);
    exp_cb.delete(); exp_req.delete(); exp_tex.delete();
    exp_err = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    issue_tex(20'h0_0ABC);
    wait_ack(200);
    wait_quiet("after_reset_tex", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
